pc_sequencer: RTL and testbench

//  Parametrised fetch-side program counter for the RV core. It generates the PC,

---
 rtl/pc_sequencer_pkg.sv | 29 ++
 rtl/pc_target_calc.sv | 71 +++++++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the fetch-side program counter.
package pc_seq_pkg;

  // Fetch control states.
  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_HALT
  } pc_state_e;

  // Next-PC source, listed from lowest to highest priority is not implied;
  // priority is resolved in pc_target_calc.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JALR,
    SEL_TRAP,
    SEL_MRET
  } pc_sel_e;

  // Sequential step and link offset in bytes.
  localparam int unsigned INSN_STEP = 4;

  // Low address bits that must be zero for a legal instruction address.
  function automatic logic [1:0] low_bits_mask(input int ialign);
    return (ialign == 16) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC computation: target adders, priority source select
// and alignment check for branch/JAL/JALR targets.
module pc_target_calc
  import pc_seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] immed_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            branch_taken_i,
  input  logic            jump_i,
  input  logic            jalr_i,
  input  logic            trap_i,
  input  logic            mret_i,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  localparam logic [1:0] LOW_MASK = low_bits_mask(IALIGN);

  logic [XLEN-1:0] align_keep;
  logic [XLEN-1:0] seq_tgt;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] trap_tgt;
  logic [XLEN-1:0] mret_tgt;
  pc_sel_e         sel;

  // All sums wrap modulo 2^XLEN; carries are dropped by the width.
  assign align_keep = {{(XLEN-2){1'b1}}, ~LOW_MASK};
  assign seq_tgt    = pc_i + XLEN'(INSN_STEP);
  assign br_tgt     = pc_i + immed_i;
  assign jalr_sum   = rs1_data_i + immed_i;
  assign jalr_tgt   = jalr_sum & ~XLEN'(1);
  // Trap and return addresses are forced legal rather than checked.
  assign trap_tgt   = trap_vec_i & align_keep;
  assign mret_tgt   = epc_i & align_keep;

  // Priority: trap > mret > jalr > branch/jal > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (trap_i)                       sel = SEL_TRAP;
    else if (mret_i)                  sel = SEL_MRET;
    else if (jalr_i)                  sel = SEL_JALR;
    else if (jump_i || branch_taken_i) sel = SEL_BR;
  end

  // Raw target of the selected source.
  always_comb begin
    target_o = seq_tgt;
    case (sel)
      SEL_BR:   target_o = br_tgt;
      SEL_JALR: target_o = jalr_tgt;
      SEL_TRAP: target_o = trap_tgt;
      SEL_MRET: target_o = mret_tgt;
      default:  target_o = seq_tgt;
    endcase
  end

  // Only computed control-flow targets can be illegal; they divert to the trap vector.
  assign misalign_o = ((sel == SEL_BR) || (sel == SEL_JALR)) &&
                      ((target_o[1:0] & LOW_MASK) != 2'b00);
  assign next_pc_o  = misalign_o ? trap_tgt : target_o;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side program counter: boot/fetch/halt control, PC register,
// imem request generation and misaligned-target reporting.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            branch_taken_i,
  input  logic            jump_i,
  input  logic            jalr_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] immed_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            imem_ready_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] maddr_q, maddr_d;

  logic [XLEN-1:0] calc_target;
  logic [XLEN-1:0] calc_next_pc;
  logic            calc_misalign;
  logic            advance;
  logic            redirect;

  pc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_calc (
    .pc_i           (pc_q),
    .immed_i        (immed_i),
    .rs1_data_i     (rs1_data_i),
    .trap_vec_i     (trap_vec_i),
    .epc_i          (epc_i),
    .branch_taken_i (branch_taken_i),
    .jump_i         (jump_i),
    .jalr_i         (jalr_i),
    .trap_i         (trap_i),
    .mret_i         (mret_i),
    .target_o       (calc_target),
    .next_pc_o      (calc_next_pc),
    .misalign_o     (calc_misalign)
  );

  // A fetch completes only when imem takes it and the pipeline is not stalled;
  // trap/mret bypass that handshake and drop any outstanding request.
  assign advance  = (state_q == S_FETCH) && imem_ready_i && !stall_i;
  assign redirect = (state_q != S_BOOT) && (trap_i || mret_i);

  // Next-state, next-PC and misalign reporting.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    maddr_d    = maddr_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (!redirect && advance && halt_i) state_d = S_HALT;
      S_HALT:  if (resume_i || redirect) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    // calc_misalign can only be set for branch/jump sources, i.e. on an advance.
    if (advance || redirect) begin
      pc_d = calc_next_pc;
      if (calc_misalign) begin
        misalign_d = 1'b1;
        maddr_d    = calc_target;
      end
    end
  end

  // State and PC registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
      maddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      maddr_q    <= maddr_d;
    end
  end

  assign imem_req_o      = (state_q == S_FETCH);
  assign imem_addr_o     = pc_q;
  assign pc_o            = pc_q;
  assign pc_plus_o       = pc_q + XLEN'(INSN_STEP);
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = maddr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a directed vector table with
// constant expectations, hand-written corner sequences, then randomized
// stimulus against a behavioural model. Two DUTs run side by side,
// one with 4-byte and one with 2-byte instruction alignment.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, ready, br, jmp, jalr, trap, mret, halt, resume;
  logic [31:0] imm, rs1, tv, epc;

  logic        req32, mis32, req16, mis16;
  logic [31:0] addr32, pc32, plus32, maddr32;
  logic [31:0] addr16, pc16, plus16, maddr16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_VEC(32'h1000), .IALIGN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .branch_taken_i(br), .jump_i(jmp), .jalr_i(jalr), .trap_i(trap), .mret_i(mret),
    .immed_i(imm), .rs1_data_i(rs1), .trap_vec_i(tv), .epc_i(epc),
    .imem_ready_i(ready), .imem_req_o(req32), .imem_addr_o(addr32), .pc_o(pc32),
    .pc_plus_o(plus32), .misalign_o(mis32), .misalign_addr_o(maddr32)
  );

  pc_sequencer #(.XLEN(32), .RESET_VEC(32'h1000), .IALIGN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .halt_i(halt), .resume_i(resume),
    .branch_taken_i(br), .jump_i(jmp), .jalr_i(jalr), .trap_i(trap), .mret_i(mret),
    .immed_i(imm), .rs1_data_i(rs1), .trap_vec_i(tv), .epc_i(epc),
    .imem_ready_i(ready), .imem_req_o(req16), .imem_addr_o(addr16), .pc_o(pc16),
    .pc_plus_o(plus16), .misalign_o(mis16), .misalign_addr_o(maddr16)
  );

  // ---------------- behavioural reference model ----------------
  // mode: 0 = just reset, 1 = fetching, 2 = halted
  int          m_mode  [2];
  logic [31:0] m_pc    [2];
  bit          m_mis   [2];
  logic [31:0] m_maddr [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pc[k] = 32'h1000; m_mis[k] = 0; m_maddr[k] = 32'h0;
    end
  endfunction

  // One clock edge of the model, k=0 for 4-byte, k=1 for 2-byte alignment.
  function automatic void model_step(input int k);
    logic [31:0] keep, tgt;
    bit moving, redir, ctrl;
    keep   = (k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
    moving = (m_mode[k] == 1) && ready && !stall;
    redir  = (m_mode[k] != 0) && (trap || mret);
    m_mis[k] = 0;
    if (m_mode[k] == 0) begin
      m_mode[k] = 1;
    end else if (redir) begin
      m_pc[k]   = (trap ? tv : epc) & keep;
      m_mode[k] = 1;
    end else if (m_mode[k] == 2) begin
      if (resume) m_mode[k] = 1;
    end else if (moving) begin
      ctrl = jalr || jmp || br;
      if (jalr)           tgt = (rs1 + imm) & 32'hFFFF_FFFE;
      else if (jmp || br) tgt = m_pc[k] + imm;
      else                tgt = m_pc[k] + 32'd4;
      if (ctrl && ((tgt & ~keep) != 32'h0)) begin
        m_pc[k] = tv & keep; m_mis[k] = 1; m_maddr[k] = tgt;
      end else begin
        m_pc[k] = tgt;
      end
      if (halt) m_mode[k] = 2;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input int k);
    if (k == 0) begin
      chk("m32_req",   32'(req32),  32'(m_mode[0] == 1));
      chk("m32_pc",    pc32,        m_pc[0]);
      chk("m32_addr",  addr32,      m_pc[0]);
      chk("m32_plus",  plus32,      m_pc[0] + 32'd4);
      chk("m32_mis",   32'(mis32),  32'(m_mis[0]));
      chk("m32_maddr", maddr32,     m_maddr[0]);
    end else begin
      chk("m16_req",   32'(req16),  32'(m_mode[1] == 1));
      chk("m16_pc",    pc16,        m_pc[1]);
      chk("m16_addr",  addr16,      m_pc[1]);
      chk("m16_plus",  plus16,      m_pc[1] + 32'd4);
      chk("m16_mis",   32'(mis16),  32'(m_mis[1]));
      chk("m16_maddr", maddr16,     m_maddr[1]);
    end
  endtask

  // Advance one edge: model follows the inputs seen at the edge, outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; ready = 1; br = 0; jmp = 0; jalr = 0; trap = 0; mret = 0;
    halt = 0; resume = 0; imm = 0; rs1 = 0; epc = 0; tv = 32'h100;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          stall, ready, br, jmp, jalr, trap, mret, halt, resume;
    logic [31:0] imm, rs1, epc;
    bit          exp_req;
    logic [31:0] exp_pc;
    bit          exp_mis;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit s, r, b, j, jr, t, m, h, rs,
                              input logic [31:0] im, r1, ep,
                              input bit q, input logic [31:0] p,
                              input bit mi, input logic [31:0] ma);
    vec_t v;
    v.stall = s; v.ready = r; v.br = b; v.jmp = j; v.jalr = jr; v.trap = t;
    v.mret = m; v.halt = h; v.resume = rs; v.imm = im; v.rs1 = r1; v.epc = ep;
    v.exp_req = q; v.exp_pc = p; v.exp_mis = mi; v.exp_maddr = ma;
    return v;
  endfunction

  initial begin
    //            st rd br jp jr tr mr ht rs  imm           rs1       epc       req pc            mis maddr
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h1000,     0, 32'h0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h1004,     0, 32'h0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h1008,     0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h1008,     0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h1008,     0, 32'h0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h1008,     0, 32'h0));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h100C,     0, 32'h0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0, 32'hFFFFFFFC, 32'h0,    32'h0,    1, 32'h1008,     0, 32'h0));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0, 32'hFFFFFFF8, 32'h0,    32'h0,    1, 32'h1000,     0, 32'h0));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 32'h8,        32'h0,    32'h0,    1, 32'h1008,     0, 32'h0));
    vecs.push_back(mk(0,1,1,0,0,1,0,0,0, 32'hFFFFFFF8, 32'h0,    32'h0,    1, 32'h0100,     0, 32'h0));
    vecs.push_back(mk(0,1,0,0,1,0,0,0,0, 32'h0,        32'h2003, 32'h0,    1, 32'h0100,     1, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h0104,     0, 32'h2002));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 32'hFFFFFEF8, 32'h0,    32'h0,    1, 32'hFFFFFFFC, 0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h0,        0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,1,0, 32'h0,        32'h0,    32'h0,    0, 32'h4,        0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    0, 32'h4,        0, 32'h2002));
    vecs.push_back(mk(0,1,1,0,0,0,0,0,0, 32'h100,      32'h0,    32'h0,    0, 32'h4,        0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,1,0,0, 32'h0,        32'h0,    32'h40,   1, 32'h40,       0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,        32'h0,    32'h0,    1, 32'h44,       0, 32'h2002));
    vecs.push_back(mk(1,1,0,0,0,0,0,1,0, 32'h0,        32'h0,    32'h0,    1, 32'h44,       0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,1,0, 32'h0,        32'h0,    32'h0,    0, 32'h48,       0, 32'h2002));
    vecs.push_back(mk(0,1,0,0,0,0,0,0,1, 32'h0,        32'h0,    32'h0,    1, 32'h48,       0, 32'h2002));
    vecs.push_back(mk(0,1,0,1,0,0,0,0,0, 32'h2,        32'h0,    32'h0,    1, 32'h100,      1, 32'h4A));
    vecs.push_back(mk(1,0,0,0,0,0,1,0,0, 32'h0,        32'h0,    32'h43,   1, 32'h40,       0, 32'h4A));

    // ---- reset and reset-state checks ----
    clear_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_req",   32'(req32), 32'h0);
    chk("rst_pc",    pc32,       32'h1000);
    chk("rst_mis",   32'(mis32), 32'h0);
    chk("rst_maddr", maddr32,    32'h0);
    chk("rst_pc16",  pc16,       32'h1000);
    $display("reset released: req=%0b pc=%h", req32, pc32);

    // ---- table-driven directed vectors ----
    foreach (vecs[i]) begin
      stall = vecs[i].stall; ready = vecs[i].ready; br = vecs[i].br; jmp = vecs[i].jmp;
      jalr = vecs[i].jalr; trap = vecs[i].trap; mret = vecs[i].mret; halt = vecs[i].halt;
      resume = vecs[i].resume; imm = vecs[i].imm; rs1 = vecs[i].rs1; epc = vecs[i].epc;
      step();
      chk($sformatf("v%0d_req", i),   32'(req32), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_pc", i),    pc32,       vecs[i].exp_pc);
      chk($sformatf("v%0d_addr", i),  addr32,     vecs[i].exp_pc);
      chk($sformatf("v%0d_plus", i),  plus32,     vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_mis", i),   32'(mis32), 32'(vecs[i].exp_mis));
      chk($sformatf("v%0d_maddr", i), maddr32,    vecs[i].exp_maddr);
      check_model(1);
      $display("vec %0d: req=%0b pc=%h mis=%0b maddr=%h | pc16=%h", i, req32, pc32, mis32, maddr32, pc16);
    end

    // ---- 2-byte alignment accepts a JALR target that 4-byte alignment rejects ----
    clear_inputs();
    jalr = 1; rs1 = 32'h2003; imm = 32'h0;
    step();
    chk("a16_jalr_pc",  pc16,        32'h2002);
    chk("a16_jalr_mis", 32'(mis16),  32'h0);
    chk("a32_jalr_pc",  pc32,        32'h100);
    chk("a32_jalr_mis", 32'(mis32),  32'h1);
    chk("a32_jalr_ma",  maddr32,     32'h2002);
    $display("jalr 0x2003: pc16=%h pc32=%h mis32=%0b", pc16, pc32, mis32);

    // ---- asynchronous reset while stalled ----
    clear_inputs();
    stall = 1;
    step();
    chk("stall_hold16", pc16, 32'h2002);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("async_pc32",  pc32,        32'h1000);
    chk("async_req32", 32'(req32),  32'h0);
    chk("async_pc16",  pc16,        32'h1000);
    chk("async_req16", 32'(req16),  32'h0);
    chk("async_ma32",  maddr32,     32'h0);
    $display("async reset: pc32=%h req32=%0b pc16=%h", pc32, req32, pc16);
    @(negedge clk);
    rst_n = 1;

    // ---- randomized stimulus against the model ----
    for (int n = 0; n < 400; n++) begin
      stall  = ($urandom_range(0, 3) == 0);
      ready  = ($urandom_range(0, 3) != 0);
      br     = ($urandom_range(0, 5) == 0);
      jmp    = ($urandom_range(0, 7) == 0);
      jalr   = ($urandom_range(0, 7) == 0);
      trap   = ($urandom_range(0, 19) == 0);
      mret   = ($urandom_range(0, 19) == 0);
      halt   = ($urandom_range(0, 11) == 0);
      resume = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 64)) - 32'd32;
        default: imm = (32'($urandom_range(0, 32)) - 32'd16) << 2;
      endcase
      rs1 = ($urandom_range(0, 2) == 0) ? $urandom : 32'h2000 + 32'($urandom_range(0, 15));
      tv  = $urandom;
      epc = $urandom;
      step();
      check_model(0);
      check_model(1);
      $display("rnd %0d: pc32=%h req32=%0b mis32=%0b pc16=%h req16=%0b mis16=%0b",
               n, pc32, req32, mis32, pc16, req16, mis16);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
